// File: rtl/ps2_action_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_action_decoder
// Description : Turns PS/2 make/brake events into held movement levels, a
//               frame-rate-limited fire pulse and a debounced pause toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_action_decoder #(
    parameter int                       KEYCODE_WIDTH        = 9,
    parameter logic [KEYCODE_WIDTH-1:0] KEY_LEFT             = 9'h06B,
    parameter logic [KEYCODE_WIDTH-1:0] KEY_RIGHT            = 9'h074,
    parameter logic [KEYCODE_WIDTH-1:0] KEY_FIRE             = 9'h029,
    parameter logic [KEYCODE_WIDTH-1:0] KEY_PAUSE            = 9'h04D,
    parameter int                       FIRE_COOLDOWN_FRAMES = 8,
    parameter int                       CNT_WIDTH            = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     startOfFrame,
    input  logic                     enable,
    input  logic [KEYCODE_WIDTH-1:0] keyCode,
    input  logic                     make,
    input  logic                     brake,
    output logic                     move_left,
    output logic                     move_right,
    output logic                     fire_pulse,
    output logic                     pause_toggle
);

    localparam logic                 c_DIR_LEFT  = 1'b0;
    localparam logic                 c_DIR_RIGHT = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_COOL_LOAD = CNT_WIDTH'(FIRE_COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_HELD = 2'd1,
        F_COOL = 2'd2
    } fire_state_e;

    logic                 w_press, w_release;
    logic                 w_hit_left, w_hit_right, w_hit_fire, w_hit_pause;

    logic                 held_l_q, held_l_d;
    logic                 held_r_q, held_r_d;
    logic                 held_f_q, held_f_d;
    logic                 held_p_q, held_p_d;
    logic                 last_dir_q, last_dir_d;
    fire_state_e          fire_state_q, fire_state_d;
    logic [CNT_WIDTH-1:0] cool_cnt_q, cool_cnt_d;
    logic                 move_left_q, move_left_d;
    logic                 move_right_q, move_right_d;
    logic                 fire_pulse_q, fire_pulse_d;
    logic                 pause_toggle_q, pause_toggle_d;

    // brake wins when both strobes arrive together
    assign w_press     = make & ~brake;
    assign w_release   = brake;
    assign w_hit_left  = (keyCode == KEY_LEFT);
    assign w_hit_right = (keyCode == KEY_RIGHT);
    assign w_hit_fire  = (keyCode == KEY_FIRE);
    assign w_hit_pause = (keyCode == KEY_PAUSE);

    always_comb begin
        held_l_d = held_l_q;
        if (w_press && w_hit_left)
            held_l_d = 1'b1;
        else if (w_release && w_hit_left)
            held_l_d = 1'b0;

        held_r_d = held_r_q;
        if (w_press && w_hit_right)
            held_r_d = 1'b1;
        else if (w_release && w_hit_right)
            held_r_d = 1'b0;

        held_f_d = held_f_q;
        if (w_press && w_hit_fire)
            held_f_d = 1'b1;
        else if (w_release && w_hit_fire)
            held_f_d = 1'b0;

        held_p_d = held_p_q;
        if (w_press && w_hit_pause)
            held_p_d = 1'b1;
        else if (w_release && w_hit_pause)
            held_p_d = 1'b0;

        // Typematic repeats also reload the direction, so a repeat can reclaim priority
        last_dir_d = last_dir_q;
        if (w_press && w_hit_left)
            last_dir_d = c_DIR_LEFT;
        else if (w_press && w_hit_right)
            last_dir_d = c_DIR_RIGHT;

        move_left_d  = enable & held_l_d & (~held_r_d | (last_dir_d == c_DIR_LEFT));
        move_right_d = enable & held_r_d & (~held_l_d | (last_dir_d == c_DIR_RIGHT));

        pause_toggle_d = w_press & w_hit_pause & ~held_p_q;

        fire_pulse_d = 1'b0;
        fire_state_d = fire_state_q;
        cool_cnt_d   = cool_cnt_q;
        if (startOfFrame && (cool_cnt_q != '0))
            cool_cnt_d = cool_cnt_q - 1'b1;

        case (fire_state_q)
            F_IDLE: begin
                if (w_press && w_hit_fire)
                    fire_state_d = F_HELD;
            end
            F_HELD: begin
                if (!held_f_q) begin
                    fire_state_d = F_IDLE;
                end else if (enable && (cool_cnt_q == '0)) begin
                    fire_pulse_d = 1'b1;
                    cool_cnt_d   = c_COOL_LOAD;
                    fire_state_d = F_COOL;
                end
            end
            F_COOL: begin
                if (cool_cnt_q == '0)
                    fire_state_d = held_f_q ? F_HELD : F_IDLE;
            end
            default: fire_state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_l_q       <= 1'b0;
            held_r_q       <= 1'b0;
            held_f_q       <= 1'b0;
            held_p_q       <= 1'b0;
            last_dir_q     <= c_DIR_RIGHT;
            fire_state_q   <= F_IDLE;
            cool_cnt_q     <= '0;
            move_left_q    <= 1'b0;
            move_right_q   <= 1'b0;
            fire_pulse_q   <= 1'b0;
            pause_toggle_q <= 1'b0;
        end else begin
            held_l_q       <= held_l_d;
            held_r_q       <= held_r_d;
            held_f_q       <= held_f_d;
            held_p_q       <= held_p_d;
            last_dir_q     <= last_dir_d;
            fire_state_q   <= fire_state_d;
            cool_cnt_q     <= cool_cnt_d;
            move_left_q    <= move_left_d;
            move_right_q   <= move_right_d;
            fire_pulse_q   <= fire_pulse_d;
            pause_toggle_q <= pause_toggle_d;
        end
    end

    assign move_left    = move_left_q;
    assign move_right   = move_right_q;
    assign fire_pulse   = fire_pulse_q;
    assign pause_toggle = pause_toggle_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_action_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_action_decoder
// Description : Directed self-checking bench for ps2_action_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_action_decoder;

    localparam logic [8:0] c_LEFT  = 9'h06B;
    localparam logic [8:0] c_RIGHT = 9'h074;
    localparam logic [8:0] c_FIRE  = 9'h029;
    localparam logic [8:0] c_PAUSE = 9'h04D;

    logic       clk;
    logic       rst;
    logic       startOfFrame;
    logic       enable;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       move_left;
    logic       move_right;
    logic       fire_pulse;
    logic       pause_toggle;

    int n_checks = 0;
    int n_errors = 0;
    int fire_cnt = 0;
    int pause_cnt = 0;
    int fire_base;
    int pause_base;

    ps2_action_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .keyCode      (keyCode),
        .make         (make),
        .brake        (brake),
        .move_left    (move_left),
        .move_right   (move_right),
        .fire_pulse   (fire_pulse),
        .pause_toggle (pause_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fire_pulse)   fire_cnt  <= fire_cnt + 1;
        if (pause_toggle) pause_cnt <= pause_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [8:0] code);
        keyCode = code;
        make    = 1'b1;
        brake   = 1'b0;
        tick();
        make    = 1'b0;
    endtask

    task automatic release_key(input logic [8:0] code, input logic with_make);
        keyCode = code;
        make    = with_make;
        brake   = 1'b1;
        tick();
        make    = 1'b0;
        brake   = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        rst = 1'b1; startOfFrame = 1'b0; enable = 1'b1;
        keyCode = '0; make = 1'b0; brake = 1'b0;
        #1;
        tick(); tick();
        check("reset_outputs", {move_left, move_right, fire_pulse, pause_toggle}, 4'b0000);
        rst = 1'b0;
        tick();

        // Basic left press / release (release sent with make also high)
        fire_base = fire_cnt; pause_base = pause_cnt;
        press(c_LEFT);
        check("t1_left_on", move_left, 1);
        check("t1_right_off", move_right, 0);
        release_key(c_LEFT, 1'b1);
        check("t1_left_off", move_left, 0);
        tick();
        check("t1_no_fire", fire_cnt - fire_base, 0);
        check("t1_no_pause", pause_cnt - pause_base, 0);

        // Left/right conflict: last pressed wins, fall back on release
        press(c_LEFT);
        press(c_RIGHT);
        check("t2_right_wins", {move_left, move_right}, 2'b01);
        press(c_LEFT);
        check("t2_repeat_left_wins", {move_left, move_right}, 2'b10);
        press(c_RIGHT);
        release_key(c_RIGHT, 1'b0);
        check("t2_fallback_left", {move_left, move_right}, 2'b10);
        release_key(c_LEFT, 1'b0);
        check("t2_all_off", {move_left, move_right}, 2'b00);

        // Held fire for 20 frames with typematic repeats
        fire_base = fire_cnt;
        press(c_FIRE);
        check("t3_no_pulse_n1", fire_pulse, 0);
        tick();
        check("t3_pulse_n2", fire_pulse, 1);
        for (int i = 0; i < 20; i++) begin
            frame();
            press(c_FIRE);
        end
        release_key(c_FIRE, 1'b0);
        tick();
        check("t3_three_pulses", fire_cnt - fire_base, 3);
        frames(5);
        check("t3_none_after_release", fire_cnt - fire_base, 3);

        // Taps: cooldown blocks until exactly 8 frames have elapsed
        fire_base = fire_cnt;
        press(c_FIRE); release_key(c_FIRE, 1'b0);
        check("t4_tap1_pulse", fire_pulse, 1);
        frames(3);
        press(c_FIRE); release_key(c_FIRE, 1'b0);
        check("t4_tap2_blocked", fire_pulse, 0);
        frames(6);
        press(c_FIRE); release_key(c_FIRE, 1'b0);
        check("t4_tap3_pulse", fire_pulse, 1);
        frames(7);
        press(c_FIRE); release_key(c_FIRE, 1'b0);
        check("t4_tap4_one_frame_short", fire_pulse, 0);
        frame();
        press(c_FIRE); release_key(c_FIRE, 1'b0);
        check("t4_tap5_pulse", fire_pulse, 1);
        tick();
        check("t4_total", fire_cnt - fire_base, 3);
        frames(9);

        // Pause debounce, with and without enable
        for (int e = 1; e >= 0; e--) begin
            enable = logic'(e);
            pause_base = pause_cnt;
            press(c_PAUSE);
            check("t5_first_toggle", pause_toggle, 1);
            for (int r = 0; r < 5; r++) press(c_PAUSE);
            check("t5_repeat_silent", pause_toggle, 0);
            release_key(c_PAUSE, 1'b0);
            press(c_PAUSE);
            check("t5_second_toggle", pause_toggle, 1);
            release_key(c_PAUSE, 1'b0);
            tick();
            check("t5_two_toggles", pause_cnt - pause_base, 2);
        end

        // Enable gating, then reset in the middle of a cooldown
        enable = 1'b0;
        fire_base = fire_cnt;
        press(c_LEFT);
        press(c_FIRE);
        frames(3);
        check("t6_gated_move", move_left, 0);
        check("t6_gated_fire", fire_cnt - fire_base, 0);
        enable = 1'b1;
        tick();
        check("t6_enable_move", move_left, 1);
        check("t6_enable_fire", fire_pulse, 1);
        frames(3);
        rst = 1'b1;
        tick();
        check("t6_rst_outputs", {move_left, move_right, fire_pulse, pause_toggle}, 4'b0000);
        rst = 1'b0;
        tick();
        check("t6_flags_cleared", move_left, 0);
        press(c_FIRE);
        tick();
        check("t6_cool_cleared_pulse", fire_pulse, 1);
        release_key(c_FIRE, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
